// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encodings, RV32I width codes
// and the request legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Legal width code and natural alignment for the given byte offset.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic legal;
    logic aligned;
    if (we) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else    legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
    aligned = 1'b1;
    if (f3[1:0] == 2'b01 && lo[0])      aligned = 1'b0;
    if (f3[1:0] == 2'b10 && lo != 2'b00) aligned = 1'b0;
    return legal && aligned;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// read-modify-write merge of store data into a RAM word.
module lsu_lane_mux
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word >> {lane, 3'b000});
    half_v = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   load_data = {{16{half_v[15]}}, half_v};
      F3_LBU:  load_data = {24'h0, byte_v};
      F3_LHU:  load_data = {16'h0, half_v};
      default: load_data = word;
    endcase

    store_data = wdata;
    case (funct3)
      F3_SB: begin
        store_data = word;
        store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      F3_SH: begin
        store_data = word;
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: one load/store per request with RMW for sub-word
// stores and a one-cycle done pulse.
//   state | meaning
//   IDLE  | waiting for req
//   READ  | RAM read in flight, counter runs down to 0
//   WRITE | single-cycle RAM write strobe
//   RESP  | done pulse, err valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we_req,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       buf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] adr_q;

  logic              req_ok;
  logic [31:0]       mux_word;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic              addr_unused;

  assign addr_unused = ^addr[31:ADDR_W+2];
  assign req_ok      = access_ok(we_req, funct3, addr[1:0]);

  // While the read completes, format straight from the RAM so rdata is valid with done.
  assign mux_word = (state_q == ST_READ) ? ram_dout : buf_q;

  lsu_lane_mux u_lane_mux (
    .word       (mux_word),
    .lane       (lo_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!req_ok)                           state_d = ST_RESP;
          else if (we_req && funct3 == F3_SW)    state_d = ST_WRITE;
          else                                   state_d = ST_READ;
        end
      end
      ST_READ:  if (cnt_q == '0) state_d = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we_req;
            f3_q    <= funct3;
            lo_q    <= addr[1:0];
            wdata_q <= wdata;
            adr_q   <= addr[ADDR_W+1:2];
            err_q   <= !req_ok;
            cnt_q   <= CNT_W'(RD_LAT - 1);
          end
        end
        ST_READ: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            buf_q <= ram_dout;
            if (!we_q) rdata_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_RESP);
  assign err     = (state_q == ST_RESP) && err_q;
  assign ram_we  = (state_q == ST_WRITE);
  assign ram_din = (state_q == ST_WRITE) ? store_data : 32'h0;
  assign ram_adr = adr_q;
  assign rdata   = rdata_q;
  assign state   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM (RD_LAT=2).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we_req;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, ram_we;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [1:0]  state;
  logic [7:0]  ram_adr;

  logic [31:0] mem [256];
  logic        mem_init;

  int n_cmp = 0;
  int n_bad = 0;

  // per-request observations
  int          r_done_cyc, r_we_cnt, r_we_cyc;
  logic        r_err, r_read;
  logic [31:0] r_din;
  logic [7:0]  r_adr;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we_req(we_req), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .state(state), .ram_adr(ram_adr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous RAM: data for the address presented at cycle 1 is valid in cycle 2.
  always @(posedge clk) begin
    if (mem_init) begin
      mem[0] <= 32'h80FF7F01;
      mem[1] <= 32'h0;
    end else if (ram_we) begin
      mem[ram_adr] <= ram_din;
    end
    ram_dout <= mem[ram_adr];
  end

  task automatic preload();
    @(negedge clk); mem_init = 1'b1;
    @(negedge clk); mem_init = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    r_done_cyc = 0; r_we_cnt = 0; r_we_cyc = 0;
    r_err = 1'b0; r_read = 1'b0; r_din = '0; r_adr = '0;
    @(negedge clk);
    req = 1'b1; we_req = we; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (state == 2'd1) r_read = 1'b1;
      if (ram_we) begin
        r_we_cnt++; r_we_cyc = cyc; r_din = ram_din; r_adr = ram_adr;
      end
      if (done) begin
        r_done_cyc = cyc; r_err = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (state !== 2'd0)    begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if ({busy, done, err, ram_we} !== 4'b0)
      begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, ram_we}); end
    n_cmp++; if (rdata !== 32'h0)   begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_cmp++; if (ram_adr !== 8'h0)  begin n_bad++; $display("FAIL reset_adr: got %h expected 0", ram_adr); end
    n_cmp++; if (ram_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h expected 0", ram_din); end
  endtask

  task automatic test_loads();
    run_req(1'b0, 3'b000, 32'h3, 32'h0);
    n_cmp++; if (r_done_cyc != 3) begin n_bad++; $display("FAIL lb_done_cycle: got %0d expected 3", r_done_cyc); end
    n_cmp++; if (r_err !== 1'b0)  begin n_bad++; $display("FAIL lb_err: got %b expected 0", r_err); end
    n_cmp++; if (rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_rdata: got %h expected ffffff80", rdata); end
    n_cmp++; if (r_we_cnt != 0)   begin n_bad++; $display("FAIL lb_no_write: got %0d expected 0", r_we_cnt); end
    run_req(1'b0, 3'b100, 32'h3, 32'h0);
    n_cmp++; if (rdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu_rdata: got %h expected 00000080", rdata); end
    run_req(1'b0, 3'b101, 32'h2, 32'h0);
    n_cmp++; if (rdata !== 32'h000080FF) begin n_bad++; $display("FAIL lhu_rdata: got %h expected 000080ff", rdata); end
    run_req(1'b0, 3'b001, 32'h0, 32'h0);
    n_cmp++; if (rdata !== 32'h00007F01) begin n_bad++; $display("FAIL lh_rdata: got %h expected 00007f01", rdata); end
    run_req(1'b0, 3'b001, 32'h2, 32'h0);
    n_cmp++; if (rdata !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh_hi_rdata: got %h expected ffff80ff", rdata); end
  endtask

  task automatic test_store_byte();
    run_req(1'b1, 3'b000, 32'h1, 32'h123456AA);
    n_cmp++; if (r_we_cnt != 1)  begin n_bad++; $display("FAIL sb_we_count: got %0d expected 1", r_we_cnt); end
    n_cmp++; if (r_we_cyc != 3)  begin n_bad++; $display("FAIL sb_we_cycle: got %0d expected 3", r_we_cyc); end
    n_cmp++; if (r_din !== 32'h80FFAA01) begin n_bad++; $display("FAIL sb_din: got %h expected 80ffaa01", r_din); end
    n_cmp++; if (r_done_cyc != 4) begin n_bad++; $display("FAIL sb_done_cycle: got %0d expected 4", r_done_cyc); end
    run_req(1'b0, 3'b010, 32'h0, 32'h0);
    n_cmp++; if (r_done_cyc != 3) begin n_bad++; $display("FAIL lw_done_cycle: got %0d expected 3", r_done_cyc); end
    n_cmp++; if (rdata !== 32'h80FFAA01) begin n_bad++; $display("FAIL lw_rdata: got %h expected 80ffaa01", rdata); end
  endtask

  task automatic test_store_half();
    run_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
    n_cmp++; if (r_adr !== 8'h40) begin n_bad++; $display("FAIL sh_adr: got %h expected 40", r_adr); end
    n_cmp++; if (r_we_cyc != 3)   begin n_bad++; $display("FAIL sh_we_cycle: got %0d expected 3", r_we_cyc); end
    n_cmp++; if (r_din !== {16'hBEEF, 16'h0} && r_din !== {16'hBEEF, mem[8'h40][15:0]})
      begin n_bad++; $display("FAIL sh_din: got %h expected upper half beef", r_din); end
  endtask

  task automatic test_store_word();
    run_req(1'b1, 3'b010, 32'h4, 32'hDEADBEEF);
    n_cmp++; if (r_adr !== 8'h01) begin n_bad++; $display("FAIL sw_adr: got %h expected 01", r_adr); end
    n_cmp++; if (r_we_cyc != 1)   begin n_bad++; $display("FAIL sw_we_cycle: got %0d expected 1", r_we_cyc); end
    n_cmp++; if (r_done_cyc != 2) begin n_bad++; $display("FAIL sw_done_cycle: got %0d expected 2", r_done_cyc); end
    n_cmp++; if (r_read !== 1'b0) begin n_bad++; $display("FAIL sw_no_read: got %b expected 0", r_read); end
    n_cmp++; if (r_din !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_din: got %h expected deadbeef", r_din); end
    @(negedge clk);
    n_cmp++; if (mem[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_mem: got %h expected deadbeef", mem[1]); end
  endtask

  task automatic test_errors();
    run_req(1'b0, 3'b010, 32'h6, 32'h0);
    n_cmp++; if (r_done_cyc != 1) begin n_bad++; $display("FAIL lw_mis_done_cycle: got %0d expected 1", r_done_cyc); end
    n_cmp++; if (r_err !== 1'b1)  begin n_bad++; $display("FAIL lw_mis_err: got %b expected 1", r_err); end
    n_cmp++; if (rdata !== 32'h80FFAA01) begin n_bad++; $display("FAIL lw_mis_rdata: got %h expected 80ffaa01", rdata); end
    run_req(1'b0, 3'b011, 32'h0, 32'h0);
    n_cmp++; if (r_done_cyc != 1) begin n_bad++; $display("FAIL ill_done_cycle: got %0d expected 1", r_done_cyc); end
    n_cmp++; if (r_err !== 1'b1)  begin n_bad++; $display("FAIL ill_err: got %b expected 1", r_err); end
    n_cmp++; if (rdata !== 32'h80FFAA01) begin n_bad++; $display("FAIL ill_rdata: got %h expected 80ffaa01", rdata); end
    run_req(1'b1, 3'b001, 32'h1, 32'hFFFFFFFF);
    n_cmp++; if (r_err !== 1'b1 || r_done_cyc != 1)
      begin n_bad++; $display("FAIL sh_mis: got err=%b cyc=%0d expected err=1 cyc=1", r_err, r_done_cyc); end
    n_cmp++; if (r_we_cnt != 0)   begin n_bad++; $display("FAIL sh_mis_no_write: got %0d expected 0", r_we_cnt); end
    n_cmp++; if (mem[0] !== 32'h80FFAA01) begin n_bad++; $display("FAIL err_mem: got %h expected 80ffaa01", mem[0]); end
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 3'b100, 32'h1, 32'h0);
    n_cmp++; if (rdata !== 32'h000000AA) begin n_bad++; $display("FAIL b2b_first: got %h expected 000000aa", rdata); end
    run_req(1'b0, 3'b000, 32'h1, 32'h0);
    n_cmp++; if (rdata !== 32'hFFFFFFAA || r_done_cyc != 3)
      begin n_bad++; $display("FAIL b2b_second: got %h cyc=%0d expected ffffffaa cyc=3", rdata, r_done_cyc); end
  endtask

  task automatic test_rst_mid_read();
    int seen_done;
    preload();
    @(negedge clk);
    req = 1'b1; we_req = 1'b1; funct3 = 3'b001; addr = 32'h2; wdata = 32'h00001234;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 2'd1 || busy !== 1'b1)
      begin n_bad++; $display("FAIL rst_read_pre: got state=%0d busy=%b expected 1/1", state, busy); end
    rst = 1'b1; #1;
    n_cmp++; if (state !== 2'd0 || ram_we !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL rst_read_abort: got state=%0d we=%b busy=%b expected 0/0/0", state, ram_we, busy); end
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || ram_we) seen_done++;
    end
    n_cmp++; if (seen_done != 0) begin n_bad++; $display("FAIL rst_read_quiet: got %0d expected 0", seen_done); end
    n_cmp++; if (mem[0] !== 32'h80FF7F01) begin n_bad++; $display("FAIL rst_read_mem: got %h expected 80ff7f01", mem[0]); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_read_rdata: got %h expected 0", rdata); end
  endtask

  task automatic test_rst_mid_write();
    int seen;
    logic hit;
    @(negedge clk);
    req = 1'b1; we_req = 1'b1; funct3 = 3'b000; addr = 32'h0; wdata = 32'h00000055;
    @(posedge clk); #1;
    req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_we) begin hit = 1'b1; break; end
    end
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rst_write_reach: got %b expected 1", hit); end
    rst = 1'b1; #1;
    n_cmp++; if (ram_we !== 1'b0 || state !== 2'd0)
      begin n_bad++; $display("FAIL rst_write_drop: got we=%b state=%0d expected 0/0", ram_we, state); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || ram_we) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_write_quiet: got %0d expected 0", seen); end
    n_cmp++; if (mem[0] !== 32'h80FF7F01) begin n_bad++; $display("FAIL rst_write_mem: got %h expected 80ff7f01", mem[0]); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we_req = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;
    test_reset();
    test_loads();
    test_store_byte();
    test_store_half();
    test_store_word();
    test_errors();
    test_back_to_back();
    test_rst_mid_read();
    test_rst_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
